// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter and access sequencer in front of the shared 512x16
// synchronous RAM. Requester 0 is the CPU load/store/fetch path, requester 1 is
// a second master (program loader, DMA). Each requester holds a command until
// it sees a one-cycle done pulse. Reads return data in a per-requester
// registered rdata output.
//
// Transaction shape: IDLE -> ACCESS (1 + WAIT_STATES cycles) -> DONE -> IDLE.
// A request first seen in IDLE at cycle t produces done in cycle
// t + 2 + WAIT_STATES. One transaction completes every 3 + WAIT_STATES cycles.
//
// Optional build macro:
//   MEM_ARB_RR_EN  - round-robin arbitration on simultaneous requests using a
//                    1-bit last-granted pointer. When undefined, requester 0
//                    has fixed priority and no pointer register exists.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   r0_cmd/addr/wdata   requester 0 command (MNONE/MREAD/MWRITE one-hot), address, write data
//   r0_done, r0_rdata   requester 0 completion pulse and registered read data
//   r1_cmd/addr/wdata   requester 1 command, address, write data
//   r1_done, r1_rdata   requester 1 completion pulse and registered read data
//   ram_addr, ram_din   RAM address and write data (held from the latched request)
//   ram_write           RAM write enable, first ACCESS cycle of a write only
//   ram_dout            RAM read data
//   busy                high whenever the sequencer is not in IDLE
//   owner               current or last granted requester
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW          = 9,
    parameter int DW          = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    r0_cmd,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_done,
    output logic [DW-1:0] r0_rdata,
    input  logic [2:0]    r1_cmd,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_done,
    output logic [DW-1:0] r1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_write,
    input  logic [DW-1:0] ram_dout,
    output logic          busy,
    output logic          owner
);

    localparam logic [2:0] MNONE  = 3'b001;
    localparam logic [2:0] MREAD  = 3'b010;
    localparam logic [2:0] MWRITE = 3'b100;

    // Counter is at least one bit wide so WAIT_STATES=0 still elaborates.
    localparam int            CW        = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_STATES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    // Only the two operation encodings count as a request; MNONE and any
    // malformed pattern are treated as idle.
    function automatic logic is_req(input logic [2:0] cmd);
        is_req = (cmd == MREAD) || (cmd == MWRITE);
    endfunction

    state_t          state_r;
    state_t          next_state_s;
    logic            req0_s;
    logic            req1_s;
    logic            grant_valid_s;
    logic            grant_s;
    logic            take_s;
    logic            access_end_s;
    logic [2:0]      sel_cmd_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_wdata_s;

    logic [CW-1:0]   cnt_r;
    logic [2:0]      cmd_r;
    logic [AW-1:0]   addr_r;
    logic [DW-1:0]   wdata_r;
    logic            owner_r;
    logic            write_r;
    logic            busy_r;
    logic            done0_r;
    logic            done1_r;
    logic [DW-1:0]   rdata0_r;
    logic [DW-1:0]   rdata1_r;

`ifdef MEM_ARB_RR_EN
    logic            ptr_r;   // last granted requester

    // Last-granted pointer; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= 1'b1;
        end else if (take_s) begin
            ptr_r <= grant_s;
        end
    end
`endif

    // Request decode and winner selection.
    always_comb begin
        req0_s        = is_req(r0_cmd);
        req1_s        = is_req(r1_cmd);
        grant_valid_s = req0_s | req1_s;
        grant_s       = 1'b0;
        if (req0_s && req1_s) begin
`ifdef MEM_ARB_RR_EN
            grant_s = ~ptr_r;
`else
            grant_s = 1'b0;
`endif
        end else if (req1_s) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Mux the winning requester's command fields for latching.
    always_comb begin
        sel_cmd_s   = r0_cmd;
        sel_addr_s  = r0_addr;
        sel_wdata_s = r0_wdata;
        if (grant_s) begin
            sel_cmd_s   = r1_cmd;
            sel_addr_s  = r1_addr;
            sel_wdata_s = r1_wdata;
        end else begin
            sel_cmd_s   = r0_cmd;
            sel_addr_s  = r0_addr;
            sel_wdata_s = r0_wdata;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic plus the grant and access-end strobes.
    always_comb begin
        next_state_s = state_r;
        take_s       = 1'b0;
        access_end_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    take_s       = 1'b1;
                    next_state_s = ACCESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == CNT_ZERO) begin
                    access_end_s = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = ACCESS;
                end
            end
            DONE: begin
                // No back-to-back grant: always pass through IDLE.
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Latch the granted request; the RAM is driven from these copies so the
    // requesters' inputs are ignored until the sequencer returns to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_r   <= MNONE;
            addr_r  <= {AW{1'b0}};
            wdata_r <= {DW{1'b0}};
            owner_r <= 1'b0;
        end else if (take_s) begin
            cmd_r   <= sel_cmd_s;
            addr_r  <= sel_addr_s;
            wdata_r <= sel_wdata_s;
            owner_r <= grant_s;
        end
    end

    // Wait-state counter: loaded at grant, counts down through ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= CNT_ZERO;
        end else if (take_s) begin
            cnt_r <= WAIT_LOAD;
        end else if ((state_r == ACCESS) && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end
    end

    // Registered strobes: write enable only in the first ACCESS cycle,
    // done for the owner in the single DONE cycle, busy outside IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_r <= 1'b0;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            write_r <= take_s && (sel_cmd_s == MWRITE);
            done0_r <= access_end_s && !owner_r;
            done1_r <= access_end_s && owner_r;
            busy_r  <= (next_state_s != IDLE);
        end
    end

    // Read data capture at the edge that ends the last ACCESS cycle; writes
    // leave both rdata registers untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata0_r <= {DW{1'b0}};
            rdata1_r <= {DW{1'b0}};
        end else if (access_end_s && (cmd_r == MREAD)) begin
            if (owner_r) begin
                rdata1_r <= ram_dout;
            end else begin
                rdata0_r <= ram_dout;
            end
        end
    end

    assign ram_addr  = addr_r;
    assign ram_din   = wdata_r;
    assign ram_write = write_r;
    assign r0_done   = done0_r;
    assign r1_done   = done1_r;
    assign r0_rdata  = rdata0_r;
    assign r1_rdata  = rdata1_r;
    assign busy      = busy_r;
    assign owner     = owner_r;

endmodule
